// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment bit order,
// digit codes, scan-select mapping and the BCD decode helper.
package seg_pkg;

    // Segment patterns are {a,b,c,d,e,f,g,dp}, active low.
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
        logic dp;
    } seg_bits_t;

    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Scan select value for each digit position, leftmost digit first.
    typedef enum logic [1:0] {
        SCAN_D3 = 2'd0,
        SCAN_D2 = 2'd1,
        SCAN_D1 = 2'd2,
        SCAN_D0 = 2'd3
    } scan_sel_e;

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Combinational decode of one BCD digit into an active-low segment pattern,
// with blanking and the decimal point applied on top.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    seg_bits_t w_pattern;

    // The decimal point is applied after blanking so a blanked digit can still show it.
    always_comb begin
        w_pattern = i_blank ? SEG_BLANK : seg_decode(i_digit);
        if (i_dp) begin
            w_pattern.dp = 1'b0;
        end
    end

    assign o_seg = w_pattern;

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit seven-segment feeder: double-buffered digit registers, scan
// prescaler, leading-zero blanking and registered segment outputs.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int LZB      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp,
    input  logic        load,
    output logic        busy,
    output logic [1:0]  enable,
    output logic [7:0]  q_7,
    output logic [7:0]  q_6,
    output logic [7:0]  q_5,
    output logic [7:0]  q_4
);

    localparam int             PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [7:0]     Q_RST_LEAD = (LZB != 0) ? SEG_BLANK : SEG_0;

    logic [PW-1:0] r_presc;
    scan_sel_e     r_scan;
    logic [15:0]   r_pendBcd;
    logic [3:0]    r_pendDp;
    logic [15:0]   r_actBcd;
    logic [3:0]    r_actDp;
    logic          r_busy;
    logic [7:0]    r_q7;
    logic [7:0]    r_q6;
    logic [7:0]    r_q5;
    logic [7:0]    r_q4;

    logic          w_tick;
    logic          w_frameEnd;
    logic [3:0]    w_d3;
    logic [3:0]    w_d2;
    logic [3:0]    w_d1;
    logic [3:0]    w_d0;
    logic          w_blank3;
    logic          w_blank2;
    logic          w_blank1;
    logic [7:0]    w_seg3;
    logic [7:0]    w_seg2;
    logic [7:0]    w_seg1;
    logic [7:0]    w_seg0;

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_frameEnd = w_tick && (r_scan == SCAN_D0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan <= SCAN_D3;
        end else if (w_tick) begin
            r_scan <= scan_sel_e'(2'(r_scan + 2'd1));
        end
    end

    // A load landing exactly on the frame boundary bypasses the pending buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pendBcd <= '0;
            r_pendDp  <= '0;
            r_actBcd  <= '0;
            r_actDp   <= '0;
            r_busy    <= 1'b0;
        end else if (load && w_frameEnd) begin
            r_actBcd <= bcd;
            r_actDp  <= dp;
            r_busy   <= 1'b0;
        end else if (load) begin
            r_pendBcd <= bcd;
            r_pendDp  <= dp;
            r_busy    <= 1'b1;
        end else if (w_frameEnd && r_busy) begin
            r_actBcd <= r_pendBcd;
            r_actDp  <= r_pendDp;
            r_busy   <= 1'b0;
        end
    end

    assign w_d3 = r_actBcd[15:12];
    assign w_d2 = r_actBcd[11:8];
    assign w_d1 = r_actBcd[7:4];
    assign w_d0 = r_actBcd[3:0];

    assign w_blank3 = (LZB != 0) && (w_d3 == 4'd0);
    assign w_blank2 = w_blank3 && (w_d2 == 4'd0);
    assign w_blank1 = w_blank2 && (w_d1 == 4'd0);

    bcd_to_seg u_seg3 (
        .i_digit (w_d3),
        .i_blank (w_blank3),
        .i_dp    (r_actDp[3]),
        .o_seg   (w_seg3)
    );

    bcd_to_seg u_seg2 (
        .i_digit (w_d2),
        .i_blank (w_blank2),
        .i_dp    (r_actDp[2]),
        .o_seg   (w_seg2)
    );

    bcd_to_seg u_seg1 (
        .i_digit (w_d1),
        .i_blank (w_blank1),
        .i_dp    (r_actDp[1]),
        .o_seg   (w_seg1)
    );

    bcd_to_seg u_seg0 (
        .i_digit (w_d0),
        .i_blank (1'b0),
        .i_dp    (r_actDp[0]),
        .o_seg   (w_seg0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q7 <= Q_RST_LEAD;
            r_q6 <= Q_RST_LEAD;
            r_q5 <= Q_RST_LEAD;
            r_q4 <= SEG_0;
        end else begin
            r_q7 <= w_seg3;
            r_q6 <= w_seg2;
            r_q5 <= w_seg1;
            r_q4 <= w_seg0;
        end
    end

    assign busy   = r_busy;
    assign enable = r_scan;
    assign q_7    = r_q7;
    assign q_6    = r_q6;
    assign q_5    = r_q5;
    assign q_4    = r_q4;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, one instance with
// leading-zero blanking and one without, driven from the same inputs.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] bcd;
    logic [3:0]  dp;

    logic        busy;
    logic [1:0]  enable;
    logic [7:0]  q7, q6, q5, q4;
    logic        busyN;
    logic [1:0]  enableN;
    logic [7:0]  n7, n6, n5, n4;

    logic [31:0] qAll;
    logic [31:0] qAllN;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    assign qAll  = {q7, q6, q5, q4};
    assign qAllN = {n7, n6, n5, n4};

    always #5 clk = ~clk;

    seg_scan_driver #(.SCAN_DIV(4), .LZB(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .bcd    (bcd),
        .dp     (dp),
        .load   (load),
        .busy   (busy),
        .enable (enable),
        .q_7    (q7),
        .q_6    (q6),
        .q_5    (q5),
        .q_4    (q4)
    );

    seg_scan_driver #(.SCAN_DIV(4), .LZB(0)) dutNoLzb (
        .clk    (clk),
        .rst    (rst),
        .bcd    (bcd),
        .dp     (dp),
        .load   (load),
        .busy   (busyN),
        .enable (enableN),
        .q_7    (n7),
        .q_6    (n6),
        .q_5    (n5),
        .q_4    (n4)
    );

    // One clock cycle; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic runTo(input int target);
        while (cyc < target) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; bcd = '0; dp = '0;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        compared++;
        if (qAll !== 32'hFFFFFF03) begin
            mismatched++;
            $display("[TB] FAIL reset_q_lzb: got %h expected %h", qAll, 32'hFFFFFF03);
        end
        compared++;
        if (qAllN !== 32'h03030303) begin
            mismatched++;
            $display("[TB] FAIL reset_q_nolzb: got %h expected %h", qAllN, 32'h03030303);
        end
        compared++;
        if (busy !== 1'b0 || enable !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy_enable: got busy=%b enable=%0d expected busy=0 enable=0", busy, enable);
        end
        for (int k = 1; k <= 16; k++) begin
            logic [1:0] expEn;
            tick();
            expEn = 2'((cyc / 4) % 4);
            compared++;
            if (enable !== expEn) begin
                mismatched++;
                $display("[TB] FAIL scan_step cyc=%0d: got %0d expected %0d", cyc, enable, expEn);
            end
        end
    endtask

    task automatic test_load_basic();
        bcd = 16'h1234; dp = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        while (cyc < 32) begin
            compared++;
            if (busy !== 1'b1 || qAll !== 32'hFFFFFF03) begin
                mismatched++;
                $display("[TB] FAIL load_pending cyc=%0d: got busy=%b q=%h expected busy=1 q=%h", cyc, busy, qAll, 32'hFFFFFF03);
            end
            tick();
        end
        compared++;
        if (busy !== 1'b0 || qAll !== 32'hFFFFFF03) begin
            mismatched++;
            $display("[TB] FAIL load_after_boundary: got busy=%b q=%h expected busy=0 q=%h", busy, qAll, 32'hFFFFFF03);
        end
        tick();
        compared++;
        if (qAll !== 32'h9F250D99) begin
            mismatched++;
            $display("[TB] FAIL load_display: got %h expected %h", qAll, 32'h9F250D99);
        end
    endtask

    task automatic test_blank_dp();
        bcd = 16'h0050; dp = 4'b1001; load = 1'b1;
        tick();
        load = 1'b0;
        runTo(49);
        compared++;
        if (qAll !== 32'hFEFF4902) begin
            mismatched++;
            $display("[TB] FAIL blank_dp_lzb: got %h expected %h", qAll, 32'hFEFF4902);
        end
        compared++;
        if (qAllN !== 32'h02034902) begin
            mismatched++;
            $display("[TB] FAIL blank_dp_nolzb: got %h expected %h", qAllN, 32'h02034902);
        end
    endtask

    task automatic test_invalid_digit();
        bcd = 16'hF007; dp = 4'b1000; load = 1'b1;
        tick();
        load = 1'b0;
        runTo(65);
        compared++;
        if (qAll !== 32'hFE03031F) begin
            mismatched++;
            $display("[TB] FAIL invalid_lzb: got %h expected %h", qAll, 32'hFE03031F);
        end
        compared++;
        if (qAllN !== 32'hFE03031F) begin
            mismatched++;
            $display("[TB] FAIL invalid_nolzb: got %h expected %h", qAllN, 32'hFE03031F);
        end
    endtask

    task automatic test_back_to_back();
        bcd = 16'h1111; dp = 4'b0000; load = 1'b1;
        tick();
        bcd = 16'h9999;
        tick();
        load = 1'b0;
        while (cyc < 81) begin
            compared++;
            if (qAll !== 32'hFE03031F) begin
                mismatched++;
                $display("[TB] FAIL b2b_hold cyc=%0d: got %h expected %h", cyc, qAll, 32'hFE03031F);
            end
            tick();
        end
        compared++;
        if (qAll !== 32'h09090909 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_final: got q=%h busy=%b expected q=%h busy=0", qAll, busy, 32'h09090909);
        end
    endtask

    task automatic test_frame_boundary();
        runTo(95);
        bcd = 16'h0008; dp = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        compared++;
        if (busy !== 1'b0 || qAll !== 32'h09090909) begin
            mismatched++;
            $display("[TB] FAIL coincident_busy: got busy=%b q=%h expected busy=0 q=%h", busy, qAll, 32'h09090909);
        end
        tick();
        compared++;
        if (qAll !== 32'hFFFFFF01 || qAllN !== 32'h03030301) begin
            mismatched++;
            $display("[TB] FAIL coincident_q: got %h/%h expected %h/%h", qAll, qAllN, 32'hFFFFFF01, 32'h03030301);
        end
        bcd = 16'h2222; load = 1'b1;
        tick();
        load = 1'b0;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL discard_busy_set: got %b expected 1", busy);
        end
        runTo(111);
        bcd = 16'h0006; load = 1'b1;
        tick();
        load = 1'b0;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL discard_busy_clear: got %b expected 0", busy);
        end
        tick();
        compared++;
        if (qAll !== 32'hFFFFFF41) begin
            mismatched++;
            $display("[TB] FAIL discard_q: got %h expected %h", qAll, 32'hFFFFFF41);
        end
        runTo(129);
        compared++;
        if (qAll !== 32'hFFFFFF41 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL discard_hold: got q=%h busy=%b expected q=%h busy=0", qAll, busy, 32'hFFFFFF41);
        end
    endtask

    task automatic test_reset_busy();
        bcd = 16'h4321; dp = 4'b1111; load = 1'b1;
        tick();
        load = 1'b0;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rst_pre_busy: got %b expected 1", busy);
        end
        tick();
        rst = 1'b1; load = 1'b1; bcd = 16'h5555;
        tick();
        rst = 1'b0; load = 1'b0;
        cyc = 0;
        compared++;
        if (enable !== 2'd0 || busy !== 1'b0 || qAll !== 32'hFFFFFF03 || qAllN !== 32'h03030303) begin
            mismatched++;
            $display("[TB] FAIL rst_mid: got en=%0d busy=%b q=%h/%h expected en=0 busy=0 q=%h/%h",
                     enable, busy, qAll, qAllN, 32'hFFFFFF03, 32'h03030303);
        end
        for (int k = 1; k <= 40; k++) begin
            logic [1:0] expEn;
            tick();
            expEn = 2'((cyc / 4) % 4);
            compared++;
            if (busy !== 1'b0 || qAll !== 32'hFFFFFF03 || enable !== expEn) begin
                mismatched++;
                $display("[TB] FAIL rst_after cyc=%0d: got busy=%b q=%h en=%0d expected busy=0 q=%h en=%0d",
                         cyc, busy, qAll, enable, 32'hFFFFFF03, expEn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_blank_dp();
        test_invalid_digit();
        test_back_to_back();
        test_frame_boundary();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
